// File: rtl/fpnew_pkg.sv
// Shared FPU types and helpers used across the fpnew datapath.
// status_t mirrors the IEEE-754 exception flags in RISC-V fflags order.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic status_t merge_status(status_t a, status_t b);
        return status_t'(a | b);
    endfunction

endpackage

// File: rtl/fpnew_divsqrt_out_buffer.sv
// In-order result buffer behind the div/sqrt unit. It lets the unit retire results
// while the arbiter stalls, and it accumulates the flags of every delivered result.
module fpnew_divsqrt_out_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned DEPTH   = 2,
    parameter type         TagType = logic,
    parameter type         AuxType = logic,
    localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [WIDTH-1:0] in_result_i,
    input  status_t         in_status_i,
    input  logic            in_ext_bit_i,
    input  TagType          in_tag_i,
    input  AuxType          in_aux_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [WIDTH-1:0] out_result_o,
    output status_t         out_status_o,
    output logic            out_ext_bit_o,
    output TagType          out_tag_o,
    output AuxType          out_aux_o,
    input  logic            clr_flags_i,
    output status_t         sticky_flags_o,
    output logic [CntW-1:0] fill_o,
    output logic            busy_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        status_t          status;
        logic             ext_bit;
        TagType           tag;
        AuxType           aux;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    status_t         sticky_q, sticky_d;
    logic            push, pop;

    // Readiness depends only on registered fill, so out_ready_i never reaches in_ready_o.
    assign in_ready_o  = (count_q != CntW'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    assign head           = mem_q[rd_ptr_q];
    assign out_result_o   = head.result;
    assign out_status_o   = head.status;
    assign out_ext_bit_o  = head.ext_bit;
    assign out_tag_o      = head.tag;
    assign out_aux_o      = head.aux;
    assign sticky_flags_o = sticky_q;
    assign fill_o         = count_q;
    assign busy_o         = (count_q != '0);

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        sticky_d = sticky_q;

        if (push) wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);

        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (pop && !push) count_d = count_q - CntW'(1);

        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end

        // Clear before merging so a result popped alongside the clear still reports.
        if (clr_flags_i) sticky_d = '0;
        if (pop)         sticky_d = merge_status(sticky_d, out_status_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            sticky_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= '{result:  in_result_i,
                                       status:  in_status_i,
                                       ext_bit: in_ext_bit_i,
                                       tag:     in_tag_i,
                                       aux:     in_aux_i};
    end

endmodule

// File: tb/tb_fpnew_divsqrt_out_buffer.sv
// Directed and random checks of the div/sqrt output buffer at DEPTH=2 and DEPTH=3.
// Both instances see the same inputs; each step checks whichever instance it targets.
module tb_fpnew_divsqrt_out_buffer;
    import fpnew_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, in_valid_i, in_ext_bit_i, flush_i, out_ready_i, clr_flags_i;
    logic [63:0] in_result_i;
    status_t     in_status_i;
    logic [7:0]  in_tag_i;
    logic [3:0]  in_aux_i;

    logic        in_ready2, out_valid2, out_ext2, busy2;
    logic [63:0] out_result2;
    status_t     out_status2, sticky2;
    logic [7:0]  out_tag2;
    logic [3:0]  out_aux2;
    logic [1:0]  fill2;

    logic        in_ready3, out_valid3, out_ext3, busy3;
    logic [63:0] out_result3;
    status_t     out_status3, sticky3;
    logic [7:0]  out_tag3;
    logic [3:0]  out_aux3;
    logic [1:0]  fill3;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpnew_divsqrt_out_buffer #(.WIDTH(64), .DEPTH(2), .TagType(logic [7:0]), .AuxType(logic [3:0])) dut2 (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready2),
        .in_result_i(in_result_i), .in_status_i(in_status_i), .in_ext_bit_i(in_ext_bit_i),
        .in_tag_i(in_tag_i), .in_aux_i(in_aux_i), .flush_i(flush_i),
        .out_valid_o(out_valid2), .out_ready_i(out_ready_i), .out_result_o(out_result2),
        .out_status_o(out_status2), .out_ext_bit_o(out_ext2), .out_tag_o(out_tag2),
        .out_aux_o(out_aux2), .clr_flags_i(clr_flags_i), .sticky_flags_o(sticky2),
        .fill_o(fill2), .busy_o(busy2));

    fpnew_divsqrt_out_buffer #(.WIDTH(64), .DEPTH(3), .TagType(logic [7:0]), .AuxType(logic [3:0])) dut3 (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready3),
        .in_result_i(in_result_i), .in_status_i(in_status_i), .in_ext_bit_i(in_ext_bit_i),
        .in_tag_i(in_tag_i), .in_aux_i(in_aux_i), .flush_i(flush_i),
        .out_valid_o(out_valid3), .out_ready_i(out_ready_i), .out_result_o(out_result3),
        .out_status_o(out_status3), .out_ext_bit_o(out_ext3), .out_tag_o(out_tag3),
        .out_aux_o(out_aux3), .clr_flags_i(clr_flags_i), .sticky_flags_o(sticky3),
        .fill_o(fill3), .busy_o(busy3));

    typedef struct {
        logic [63:0] r;
        logic [7:0]  t;
        logic [4:0]  s;
    } ent_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] r, input logic [7:0] t, input logic [4:0] s);
        in_valid_i  = v;
        in_result_i = r;
        in_tag_i    = t;
        in_status_i = s;
    endtask

    initial begin
        ent_t        q2[$], q3[$];
        ent_t        e;
        logic [4:0]  st2, st3;
        logic        pu2, po2, pu3, po3;

        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; clr_flags_i = 1'b0;
        in_ext_bit_i = 1'b0; in_aux_i = 4'h0;
        drive(1'b1, 64'h1, 8'h0, 5'b0);

        // 1: reset with in_valid high
        tick(); tick();
        rst_i = 1'b0; in_valid_i = 1'b0;
        chk("rst_out_valid", 64'(out_valid2), 64'd0);
        chk("rst_fill",      64'(fill2),      64'd0);
        chk("rst_in_ready",  64'(in_ready2),  64'd1);
        chk("rst_sticky",    64'(sticky2),    64'd0);
        chk("rst_busy",      64'(busy2),      64'd0);
        chk("rst_fill3",     64'(fill3),      64'd0);

        // 2: fill DEPTH=2, third push stalls, then drain in order
        drive(1'b1, 64'h3FF0000000000000, 8'd1, 5'b0); tick();
        chk("p1_fill",  64'(fill2),     64'd1);
        chk("p1_valid", 64'(out_valid2), 64'd1);
        chk("p1_tag",   64'(out_tag2),  64'd1);
        drive(1'b1, 64'h4000000000000000, 8'd2, 5'b0); tick();
        chk("p2_fill",  64'(fill2),     64'd2);
        chk("p2_ready", 64'(in_ready2), 64'd0);
        drive(1'b1, 64'h4008000000000000, 8'd3, 5'b0); tick();
        chk("p3_stall_fill", 64'(fill2), 64'd2);
        chk("p3_fill3",      64'(fill3), 64'd3);
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        chk("pop1_res", out_result2,    64'h3FF0000000000000);
        chk("pop1_tag", 64'(out_tag2),  64'd1);
        tick();
        chk("pop1_fill", 64'(fill2),    64'd1);
        chk("pop2_res",  out_result2,   64'h4000000000000000);
        chk("pop2_tag",  64'(out_tag2), 64'd2);
        tick();
        chk("pop2_fill",  64'(fill2),      64'd0);
        chk("pop2_valid", 64'(out_valid2), 64'd0);
        chk("d3_left",    64'(fill3),      64'd1);

        // 3: DEPTH=3 at fill 1, push+pop for 6 cycles, pointers wrap
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 64'h100 + 64'(i), 8'd10 + 8'(i), 5'b0);
            chk($sformatf("pp%0d_head", i), 64'(out_tag3), (i == 0) ? 64'd3 : 64'd9 + 64'(i));
            tick();
            chk($sformatf("pp%0d_fill", i), 64'(fill3), 64'd1);
        end
        chk("pp_last_res", out_result3, 64'h105);
        in_valid_i = 1'b0; tick();
        chk("pp_drain", 64'(fill3), 64'd0);

        // 4: sticky with clear on the second pop
        out_ready_i = 1'b0;
        drive(1'b1, 64'h20, 8'd20, 5'b00001); tick();
        drive(1'b1, 64'h21, 8'd21, 5'b10000); tick();
        in_valid_i = 1'b0; out_ready_i = 1'b1; tick();
        chk("stk_first", 64'(sticky2), 64'h01);
        clr_flags_i = 1'b1; tick();
        chk("stk_clr_pop", 64'(sticky2), 64'h10);
        chk("stk_clr_pop3", 64'(sticky3), 64'h10);
        clr_flags_i = 1'b0; tick();
        chk("stk_hold", 64'(sticky2), 64'h10);

        // 5: flush keeps sticky and drops the concurrent push
        clr_flags_i = 1'b1; out_ready_i = 1'b0; tick();
        clr_flags_i = 1'b0;
        drive(1'b1, 64'h30, 8'd30, 5'b01000); tick();
        in_valid_i = 1'b0; out_ready_i = 1'b1; tick();
        chk("fl_sticky_pre", 64'(sticky2), 64'h08);
        out_ready_i = 1'b0;
        drive(1'b1, 64'h31, 8'd31, 5'b00010); tick();
        drive(1'b1, 64'h32, 8'd32, 5'b00010); tick();
        chk("fl_fill_pre", 64'(fill2), 64'd2);
        flush_i = 1'b1; out_ready_i = 1'b1;
        drive(1'b1, 64'h33, 8'd33, 5'b00100); tick();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("fl_fill",   64'(fill2),      64'd0);
        chk("fl_valid",  64'(out_valid2), 64'd0);
        chk("fl_ready",  64'(in_ready2),  64'd1);
        chk("fl_sticky", 64'(sticky2),    64'h08);
        tick();
        chk("fl_dropped",  64'(fill2), 64'd0);
        chk("fl_dropped3", 64'(fill3), 64'd0);

        // 6: reset overrides flush while full
        drive(1'b1, 64'h40, 8'd40, 5'b0); tick(); tick();
        chk("rs_fill_pre", 64'(fill2), 64'd2);
        rst_i = 1'b1; flush_i = 1'b1; out_ready_i = 1'b1; tick();
        rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("rs_fill",   64'(fill2),      64'd0);
        chk("rs_valid",  64'(out_valid2), 64'd0);
        chk("rs_ready",  64'(in_ready2),  64'd1);
        chk("rs_sticky", 64'(sticky2),    64'd0);

        // random push/pop scoreboard on both depths
        st2 = '0; st3 = '0;
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom), 5'($urandom));
            out_ready_i = ($urandom_range(0, 2) != 0);
            chk("rnd_rdy2", 64'(in_ready2), 64'(q2.size() < 2));
            chk("rnd_rdy3", 64'(in_ready3), 64'(q3.size() < 3));
            chk("rnd_vld2", 64'(out_valid2), 64'(q2.size() != 0));
            chk("rnd_vld3", 64'(out_valid3), 64'(q3.size() != 0));
            if (q2.size() != 0) begin
                chk("rnd_res2", out_result2, q2[0].r);
                chk("rnd_tag2", 64'(out_tag2), 64'(q2[0].t));
            end
            if (q3.size() != 0) begin
                chk("rnd_res3", out_result3, q3[0].r);
                chk("rnd_sts3", 64'(out_status3), 64'(q3[0].s));
            end
            pu2 = in_valid_i && (q2.size() < 2); po2 = out_ready_i && (q2.size() != 0);
            pu3 = in_valid_i && (q3.size() < 3); po3 = out_ready_i && (q3.size() != 0);
            e.r = in_result_i; e.t = in_tag_i; e.s = in_status_i;
            if (po2) st2 |= q2.pop_front().s;
            if (po3) st3 |= q3.pop_front().s;
            if (pu2) q2.push_back(e);
            if (pu3) q3.push_back(e);
            tick();
            chk("rnd_fill2",   64'(fill2),   64'(q2.size()));
            chk("rnd_fill3",   64'(fill3),   64'(q3.size()));
            chk("rnd_sticky3", 64'(sticky3), 64'(st3));
        end
        chk("rnd_sticky2", 64'(sticky2), 64'(st2));

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
